multi_debounce: RTL

MULTI_DEBOUNCE -- requirements
Module: multi_debounce

---
 rtl/multi_debounce.sv | 120 ++++++++++++
 1 files changed

// File: rtl/multi_debounce.sv
// Multi-channel button debouncer: synchroniser, per-channel stability counter, edge pulses.
// Optional long-press detection is enabled by defining MULTI_DEBOUNCE_HOLD_EN.
module multi_debounce #(
    parameter int unsigned CHANNELS      = 4,
    parameter int unsigned STABLE_CYCLES = 262144,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned HOLD_CYCLES   = 50000000
) (
    input  logic                clk,
    input  logic                DB_reset_n,
    input  logic                count_en,
    input  logic [CHANNELS-1:0] button,
    output logic [CHANNELS-1:0] button_output,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] hold
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    // Reject configurations outside the supported range at elaboration.
    if (CHANNELS < 1 || CHANNELS > 32 || STABLE_CYCLES < 2 || SYNC_STAGES < 2 || HOLD_CYCLES < 1)
    begin : g_bad_params
        $error("multi_debounce: parameter out of range");
    end

    logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
    logic [CHANNELS-1:0] s;
    logic [CNT_W-1:0]    cnt_q  [CHANNELS];
    logic [CNT_W-1:0]    cnt_d  [CHANNELS];
    logic [CHANNELS-1:0] out_d;
    logic [CHANNELS-1:0] rise_d;
    logic [CHANNELS-1:0] fall_d;

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge DB_reset_n) begin
        if (!DB_reset_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
        end else begin
            sync_q[0] <= button;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end

    // Counter restarts whenever the synchronised level agrees with the output.
    always_comb begin
        cnt_d  = cnt_q;
        out_d  = button_output;
        rise_d = '0;
        fall_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (s[i] == button_output[i]) begin
                cnt_d[i] = '0;
            end else if (count_en) begin
                if (cnt_q[i] == CNT_LAST) begin
                    cnt_d[i]  = '0;
                    out_d[i]  = s[i];
                    rise_d[i] = s[i];
                    fall_d[i] = !s[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge DB_reset_n) begin
        if (!DB_reset_n) begin
            for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= '0;
            button_output <= '0;
            rise          <= '0;
            fall          <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= cnt_d[i];
            button_output <= out_d;
            rise          <= rise_d;
            fall          <= fall_d;
        end
    end

`ifdef MULTI_DEBOUNCE_HOLD_EN
    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    logic [HOLD_W-1:0]   hold_cnt_q [CHANNELS];
    logic [HOLD_W-1:0]   hold_cnt_d [CHANNELS];
    logic [CHANNELS-1:0] hold_d;

    // Hold drops on the same edge the debounced output falls.
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        hold_d     = hold;
        for (int i = 0; i < CHANNELS; i++) begin
            if (!button_output[i] || fall_d[i]) begin
                hold_cnt_d[i] = '0;
                hold_d[i]     = 1'b0;
            end else if (count_en && hold_cnt_q[i] != HOLD_MAX) begin
                hold_cnt_d[i] = hold_cnt_q[i] + HOLD_W'(1);
                if (hold_cnt_q[i] == HOLD_LAST) hold_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge DB_reset_n) begin
        if (!DB_reset_n) begin
            for (int i = 0; i < CHANNELS; i++) hold_cnt_q[i] <= '0;
            hold <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) hold_cnt_q[i] <= hold_cnt_d[i];
            hold <= hold_d;
        end
    end
`else
    assign hold = '0;
`endif

endmodule
